// File: rtl/determ_fxp_to_bits.sv
// determ_fxp_to_bits
// Deterministic bitstream generator: turns a signed fixed-point value x into
// a stream of len bits (1 = +1, 0 = -1) whose mean tracks x. A first-order
// error-feedback accumulator decides each bit.
//
// Optional feature macro: DETERM_GEN_SAT_EN
//   defined   : x is clamped to [-1.0, +1.0] on start and the sat port exists
//   undefined : x is used unmodified; caller keeps it inside [-1.0, +1.0]
//
// Handshake: bit_out is offered while bit_valid is high and is consumed on a
// cycle where bit_ready is also high. done pulses for one cycle after the
// last bit is consumed, and the block is back in IDLE the cycle after that.

module determ_fxp_to_bits #(
  parameter int BIT_WIDTH = 16,
  parameter int INT_WIDTH = 1,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [BIT_WIDTH-1:0] x,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 bit_out,
  output logic                 bit_valid,
  input  logic                 bit_ready,
  output logic                 busy,
  output logic                 done
`ifdef DETERM_GEN_SAT_EN
  ,
  output logic                 sat
`endif
);

  // Fractional bits of x; 1.0 is 1 << FRAC.
  localparam int FRAC = BIT_WIDTH - INT_WIDTH;

  // Accumulator / error width. With xr in [-1, +1] the accumulator stays in
  // [-1, +1), so e = acc + xr lies in [-2, +2) and never needs more than
  // FRAC + 3 bits (sign, two integer bits, fraction).
  localparam int AW = FRAC + 3;

  // Working width used when bringing x into the accumulator domain; it is
  // wide enough for both the raw input and the accumulator.
  localparam int XW = (BIT_WIDTH > AW) ? BIT_WIDTH : AW;

  // +1.0 in the accumulator domain.
  localparam logic signed [AW-1:0] ONE = {{(AW-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Latched operand, latched length, error accumulator and bit counter.
  logic signed [AW-1:0]  xr;
  logic [LEN_WIDTH-1:0]  lr;
  logic signed [AW-1:0]  acc;
  logic [LEN_WIDTH-1:0]  cnt;

  // Combinational decision signals.
  logic signed [AW-1:0]  e;
  logic signed [AW-1:0]  acc_upd;
  logic                  pos;
  logic                  xfer;
  logic                  last;
  logic signed [AW-1:0]  xin;
  logic                  accept;

  // Sign-extend (or, for very wide integer parts, wrap) the raw input into
  // the accumulator width. Only meaningful for in-range inputs.
  function automatic logic signed [AW-1:0] fit_acc(input logic signed [BIT_WIDTH-1:0] v);
    logic signed [XW-1:0] t;
    t = XW'(v);
    return t[AW-1:0];
  endfunction

`ifdef DETERM_GEN_SAT_EN
  localparam logic signed [XW-1:0] ONE_X = XW'(ONE);

  // True when the raw input lies outside [-1.0, +1.0].
  function automatic logic over_range(input logic signed [BIT_WIDTH-1:0] v);
    logic signed [XW-1:0] t;
    t = XW'(v);
    return (t > ONE_X) || (t < -ONE_X);
  endfunction

  // Clamp the raw input to [-1.0, +1.0] in the accumulator domain.
  function automatic logic signed [AW-1:0] clamp_fxp(input logic signed [BIT_WIDTH-1:0] v);
    logic signed [XW-1:0] t;
    t = XW'(v);
    if (t > ONE_X) begin
      return ONE;
    end else if (t < -ONE_X) begin
      return -ONE;
    end else begin
      return t[AW-1:0];
    end
  endfunction
`endif

  // Operand as it will be latched on an accepted start.
  always_comb begin
`ifdef DETERM_GEN_SAT_EN
    xin = clamp_fxp(signed'(x));
`else
    xin = fit_acc(signed'(x));
`endif
  end

  // Error-feedback decision: emit +1 when the running error is non-negative,
  // then feed back the quantisation error (subtract or add 1.0).
  always_comb begin
    e       = acc + xr;
    pos     = ~e[AW-1];
    acc_upd = pos ? (e - ONE) : (e + ONE);
    xfer    = bit_valid & bit_ready;
    last    = (cnt == (lr - LEN_ONE));
    accept  = (state == S_IDLE) & start;
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: start only counts in IDLE; DONE always lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (len != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (xfer && last) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from state; bit_out is forced low outside RUN so it reads
  // 0 whenever no bit is being offered.
  always_comb begin
    bit_valid = (state == S_RUN);
    bit_out   = (state == S_RUN) & pos;
    busy      = (state == S_RUN) | (state == S_DONE);
    done      = (state == S_DONE);
  end

  // Operand, length, accumulator and counter. The accumulator and counter only
  // move on a transfer, which keeps bit_out stable while the consumer stalls.
  always_ff @(posedge CLK) begin
    if (RST) begin
      xr  <= '0;
      lr  <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      xr  <= xin;
      lr  <= len;
      acc <= '0;
      cnt <= '0;
    end else if ((state == S_RUN) && xfer) begin
      acc <= acc_upd;
      cnt <= cnt + LEN_ONE;
    end
  end

`ifdef DETERM_GEN_SAT_EN
  // Saturation flag: reflects the clamp of the most recently accepted start.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sat <= 1'b0;
    end else if (accept) begin
      sat <= over_range(signed'(x));
    end
  end
`endif

endmodule

// File: tb/tb_determ_fxp_to_bits.sv
// Self-checking bench for determ_fxp_to_bits. Uses INT_WIDTH = 2 so that
// +1.0 and out-of-range values such as +1.5 are representable in x.

module tb_determ_fxp_to_bits;

  localparam int BW   = 16;
  localparam int IW   = 2;
  localparam int LW   = 8;
  localparam int FRAC = BW - IW;
  localparam int ONE  = 1 << FRAC;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [BW-1:0] x;
  logic [LW-1:0] len;
  logic          bit_out;
  logic          bit_valid;
  logic          bit_ready;
  logic          busy;
  logic          done;
`ifdef DETERM_GEN_SAT_EN
  logic          sat;
`endif

  determ_fxp_to_bits #(
    .BIT_WIDTH (BW),
    .INT_WIDTH (IW),
    .LEN_WIDTH (LW)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .start     (start),
    .x         (x),
    .len       (len),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .busy      (busy),
    .done      (done)
`ifdef DETERM_GEN_SAT_EN
    ,
    .sat       (sat)
`endif
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Observations gathered by run_stream.
  logic got_bits[$];
  logic stall_obs[$];
  logic exp_bits[$];
  int   done_at;
  int   n_valid;
  int   done_after;
  int   busy_after;
  int   busy_gap;
  int   timeout;

  // Reference: sigma-delta on plain integers, value scaled by ONE.
  function automatic void build_expected(input int xv, input int ln);
    int acc;
    int e;
    exp_bits.delete();
    acc = 0;
    for (int i = 0; i < ln; i++) begin
      e = acc + xv;
      if (e >= 0) begin
        exp_bits.push_back(1'b1);
        acc = e - ONE;
      end else begin
        exp_bits.push_back(1'b0);
        acc = e + ONE;
      end
    end
  endfunction

  // Drive one stream from IDLE and record what comes out. Stalls the consumer
  // for stall_cycles valid cycles once stall_after bits have been taken. With
  // poke set, start is pulsed again (with other operands) while running.
  task automatic run_stream(input int xv, input int ln, input int stall_after,
                            input int stall_cycles, input bit poke);
    int xfers;
    int stall_left;
    int budget;
    got_bits.delete();
    stall_obs.delete();
    done_at    = -1;
    n_valid    = 0;
    busy_gap   = 0;
    timeout    = 0;
    done_after = -1;
    busy_after = -1;
    start      = 1'b1;
    x          = xv[BW-1:0];
    len        = ln[LW-1:0];
    bit_ready  = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    xfers      = 0;
    stall_left = stall_cycles;
    budget     = ln + stall_cycles + 10;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (done === 1'b1) begin
        done_at = cyc;
        break;
      end
      if (busy !== 1'b1) busy_gap++;
      if (poke && cyc == 2) begin
        start = 1'b1;
        x     = 16'hC000;
        len   = 8'd1;
      end else begin
        start = 1'b0;
      end
      if (bit_valid === 1'b1 && xfers == stall_after && stall_left > 0) begin
        bit_ready = 1'b0;
        stall_left--;
        stall_obs.push_back(bit_out);
      end else begin
        bit_ready = 1'b1;
      end
      if (bit_valid === 1'b1) begin
        n_valid++;
        if (bit_ready) begin
          got_bits.push_back(bit_out);
          xfers++;
        end
      end
      @(posedge clk); #1;
    end
    start     = 1'b0;
    bit_ready = 1'b1;
    if (done_at < 0) begin
      timeout = 1;
    end else begin
      @(posedge clk); #1;
      done_after = int'(done);
      busy_after = int'(busy);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    start     = 1'b0;
    x         = '0;
    len       = '0;
    bit_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (bit_out !== 1'b0) begin miscompares++; $display("FAIL reset_bit_out got=%b exp=0", bit_out); end
    vectors++; if (bit_valid !== 1'b0) begin miscompares++; $display("FAIL reset_bit_valid got=%b exp=0", bit_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
`ifdef DETERM_GEN_SAT_EN
    vectors++; if (sat !== 1'b0) begin miscompares++; $display("FAIL reset_sat got=%b exp=0", sat); end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_stream();
    logic [7:0] gv;
    int bad;
    run_stream(0, 8, 99, 0, 1'b0);
    build_expected(0, 8);
    gv = '0;
    bad = 0;
    for (int i = 0; i < got_bits.size() && i < 8; i++) gv[7-i] = got_bits[i];
    for (int i = 0; i < 8; i++) if (i >= got_bits.size() || got_bits[i] !== exp_bits[i]) bad++;
    vectors++; if (timeout != 0) begin miscompares++; $display("FAIL zero_timeout got=%0d exp=0", timeout); end
    vectors++; if (got_bits.size() != 8) begin miscompares++; $display("FAIL zero_count got=%0d exp=8", got_bits.size()); end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL zero_model got=%b bad_bits=%0d exp=0", gv, bad); end
    vectors++; if (gv !== 8'b1010_1010) begin miscompares++; $display("FAIL zero_bits got=%b exp=10101010", gv); end
    vectors++; if (done_at != 9) begin miscompares++; $display("FAIL zero_done_cycle got=%0d exp=9", done_at); end
    vectors++; if (busy_gap != 0) begin miscompares++; $display("FAIL zero_busy_gap got=%0d exp=0", busy_gap); end
    vectors++; if (done_after != 0) begin miscompares++; $display("FAIL zero_done_width got=%0d exp=0", done_after); end
    vectors++; if (busy_after != 0) begin miscompares++; $display("FAIL zero_idle_busy got=%0d exp=0", busy_after); end
  endtask

  task automatic test_patterns();
    logic [3:0] gv;
    run_stream(ONE / 2, 4, 99, 0, 1'b0);
    gv = '0;
    for (int i = 0; i < got_bits.size() && i < 4; i++) gv[3-i] = got_bits[i];
    vectors++; if (got_bits.size() != 4 || gv !== 4'b1101) begin miscompares++; $display("FAIL half_bits got=%b n=%0d exp=1101", gv, got_bits.size()); end
    vectors++; if (done_at != 5) begin miscompares++; $display("FAIL half_done_cycle got=%0d exp=5", done_at); end
    run_stream(-ONE, 4, 99, 0, 1'b0);
    gv = '1;
    for (int i = 0; i < got_bits.size() && i < 4; i++) gv[3-i] = got_bits[i];
    vectors++; if (got_bits.size() != 4 || gv !== 4'b0000) begin miscompares++; $display("FAIL minus_one_bits got=%b n=%0d exp=0000", gv, got_bits.size()); end
    run_stream(ONE, 4, 99, 0, 1'b0);
    gv = '0;
    for (int i = 0; i < got_bits.size() && i < 4; i++) gv[3-i] = got_bits[i];
    vectors++; if (got_bits.size() != 4 || gv !== 4'b1111) begin miscompares++; $display("FAIL plus_one_bits got=%b n=%0d exp=1111", gv, got_bits.size()); end
  endtask

  task automatic test_backpressure();
    logic [3:0] gv;
    int unstable;
    run_stream(ONE / 2, 4, 1, 3, 1'b0);
    gv = '0;
    for (int i = 0; i < got_bits.size() && i < 4; i++) gv[3-i] = got_bits[i];
    unstable = 0;
    foreach (stall_obs[i]) if (stall_obs[i] !== 1'b1) unstable++;
    vectors++; if (got_bits.size() != 4 || gv !== 4'b1101) begin miscompares++; $display("FAIL bp_bits got=%b n=%0d exp=1101", gv, got_bits.size()); end
    vectors++; if (stall_obs.size() != 3) begin miscompares++; $display("FAIL bp_stall_cycles got=%0d exp=3", stall_obs.size()); end
    vectors++; if (unstable != 0) begin miscompares++; $display("FAIL bp_hold got=%0d changed exp=0", unstable); end
    vectors++; if (done_at != 8) begin miscompares++; $display("FAIL bp_done_cycle got=%0d exp=8", done_at); end
  endtask

  task automatic test_len0();
    run_stream(ONE / 4, 0, 99, 0, 1'b0);
    vectors++; if (done_at != 1) begin miscompares++; $display("FAIL len0_done_cycle got=%0d exp=1", done_at); end
    vectors++; if (n_valid != 0) begin miscompares++; $display("FAIL len0_valid got=%0d exp=0", n_valid); end
    vectors++; if (busy_after != 0) begin miscompares++; $display("FAIL len0_idle_busy got=%0d exp=0", busy_after); end
  endtask

  task automatic test_start_ignored();
    logic [3:0] gv;
    run_stream(0, 4, 99, 0, 1'b1);
    gv = '0;
    for (int i = 0; i < got_bits.size() && i < 4; i++) gv[3-i] = got_bits[i];
    vectors++; if (got_bits.size() != 4 || gv !== 4'b1010) begin miscompares++; $display("FAIL busy_start_bits got=%b n=%0d exp=1010", gv, got_bits.size()); end
    vectors++; if (done_at != 5) begin miscompares++; $display("FAIL busy_start_done got=%0d exp=5", done_at); end
  endtask

  task automatic test_reset_midstream();
    int seen;
    logic [1:0] gv;
    start     = 1'b1;
    x         = '0;
    len       = 8'd8;
    bit_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++; if ({bit_out, bit_valid, busy, done} !== 4'b0000) begin miscompares++; $display("FAIL midrst_outputs got=%b exp=0000", {bit_out, bit_valid, busy, done}); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (done !== 1'b0 || busy !== 1'b0 || bit_valid !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    vectors++; if (seen != 0) begin miscompares++; $display("FAIL midrst_quiet got=%0d active_cycles exp=0", seen); end
    run_stream(0, 2, 99, 0, 1'b0);
    gv = '0;
    for (int i = 0; i < got_bits.size() && i < 2; i++) gv[1-i] = got_bits[i];
    vectors++; if (got_bits.size() != 2 || gv !== 2'b10) begin miscompares++; $display("FAIL midrst_restart got=%b n=%0d exp=10", gv, got_bits.size()); end
  endtask

  task automatic test_random();
    int xv, ln, sa, sc, bad, sum, exp_done, err;
    for (int it = 0; it < 24; it++) begin
      xv = int'($urandom_range(0, 2 * ONE)) - ONE;
      ln = int'($urandom_range(1, 40));
      sa = int'($urandom_range(0, ln + 2));
      sc = int'($urandom_range(0, 4));
      run_stream(xv, ln, sa, sc, 1'b0);
      build_expected(xv, ln);
      bad = 0;
      sum = 0;
      for (int i = 0; i < ln; i++) begin
        if (i >= got_bits.size() || got_bits[i] !== exp_bits[i]) bad++;
        if (i < got_bits.size()) sum += (got_bits[i] === 1'b1) ? 1 : -1;
      end
      exp_done = ln + 1 + ((sa < ln) ? sc : 0);
      err = sum * ONE - ln * xv;
      if (err < 0) err = -err;
      vectors++; if (got_bits.size() != ln || bad != 0) begin miscompares++; $display("FAIL rand_bits it=%0d x=%0d len=%0d got_n=%0d bad=%0d exp_n=%0d", it, xv, ln, got_bits.size(), bad, ln); end
      vectors++; if (done_at != exp_done) begin miscompares++; $display("FAIL rand_done it=%0d got=%0d exp=%0d", it, done_at, exp_done); end
      vectors++; if (err > 2 * ONE) begin miscompares++; $display("FAIL rand_accuracy it=%0d got_err=%0d exp_max=%0d", it, err, 2 * ONE); end
    end
  endtask

  task automatic test_saturation();
    logic [3:0] gv;
`ifdef DETERM_GEN_SAT_EN
    run_stream(ONE + ONE / 2, 4, 99, 0, 1'b0);
    gv = '0;
    for (int i = 0; i < got_bits.size() && i < 4; i++) gv[3-i] = got_bits[i];
    vectors++; if (got_bits.size() != 4 || gv !== 4'b1111) begin miscompares++; $display("FAIL sat_pos_bits got=%b exp=1111", gv); end
    vectors++; if (sat !== 1'b1) begin miscompares++; $display("FAIL sat_pos_flag got=%b exp=1", sat); end
    run_stream(-(ONE + 3 * ONE / 4), 4, 99, 0, 1'b0);
    gv = '1;
    for (int i = 0; i < got_bits.size() && i < 4; i++) gv[3-i] = got_bits[i];
    vectors++; if (got_bits.size() != 4 || gv !== 4'b0000) begin miscompares++; $display("FAIL sat_neg_bits got=%b exp=0000", gv); end
    vectors++; if (sat !== 1'b1) begin miscompares++; $display("FAIL sat_neg_flag got=%b exp=1", sat); end
    run_stream(ONE / 4, 4, 99, 0, 1'b0);
    vectors++; if (sat !== 1'b0) begin miscompares++; $display("FAIL sat_clear_flag got=%b exp=0", sat); end
`else
    run_stream(ONE, 6, 99, 0, 1'b0);
    gv = '0;
    for (int i = 0; i < got_bits.size() && i < 4; i++) gv[3-i] = got_bits[i];
    vectors++; if (got_bits.size() != 6 || gv !== 4'b1111) begin miscompares++; $display("FAIL full_scale_bits got=%b n=%0d exp=1111", gv, got_bits.size()); end
`endif
  endtask

  initial begin
    test_reset();
    test_zero_stream();
    test_patterns();
    test_backpressure();
    test_len0();
    test_start_ignored();
    test_reset_midstream();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
